// File: rtl/riscv_check_pkg.sv
// riscv_check_pkg: shared types and constants for the retire checker.
//   - state_e      : checker FSM states (IDLE, RUN, PASS_ST, FAIL_ST)
//   - FC_*         : FAIL_CODE encodings
//   - *_DEF        : default sizing for the checker and its table
package riscv_check_pkg;

  localparam int NUM_TEST_DEF       = 21;
  localparam int IDX_W_DEF          = 5;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_MISMATCH   = 2'b00;
  localparam logic [1:0] FC_SKIPPED    = 2'b01;
  localparam logic [1:0] FC_INCOMPLETE = 2'b10;
  localparam logic [1:0] FC_TIMEOUT    = 2'b11;

endpackage

// File: rtl/retire_exp_table.sv
// retire_exp_table: expected-result table, NUM_TEST x 64-bit registers.
//   Entry layout: {exp_num_inst[31:0], exp_ans[31:0]}.
// Ports:
//   CLK      clock
//   we_i     write strobe (caller gates it by FSM state)
//   waddr_i  write index; indices >= NUM_TEST are dropped here
//   wdata_i  entry to write
//   raddr_i  combinational read index (checker pointer)
//   rdata_o  entry at raddr_i, zero when raddr_i is out of range
// Storage has no reset so a loaded table survives a checker reset.
module retire_exp_table
  import riscv_check_pkg::*;
#(
  parameter int NUM_TEST = NUM_TEST_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic             CLK,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [63:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [63:0]      rdata_o
);

  localparam logic [IDX_W:0] NT_W = (IDX_W+1)'(NUM_TEST);

  logic [63:0] mem_q [NUM_TEST];

  always_ff @(posedge CLK) begin
    if (we_i && ({1'b0, waddr_i} < NT_W)) mem_q[waddr_i] <= wdata_i;
  end

  // The pointer legitimately reaches NUM_TEST after the final entry passes.
  assign rdata_o = ({1'b0, raddr_i} < NT_W) ? mem_q[raddr_i] : 64'd0;

endmodule

// File: rtl/riscv_retire_checker.sv
// riscv_retire_checker: compares a core's retired-instruction count and
// result port against a preloaded table of expected (count, answer) pairs.
// Optional feature: define RETIRE_CHECKER_TIMEOUT_EN to enable the RUN
// watchdog (FAIL_CODE 11 when CYCLE reaches TIMEOUT_CYCLES).
// Ports:
//   CLK, RSTn                 clock, synchronous active-low reset
//   EXP_WE/ADDR/NUM_INST/ANS  table load port (IDLE only)
//   N_ENTRIES, START          active entry count and run trigger
//   NUM_INST, OUTPUT_PORT     core retire count / result (RUN only)
//   HALT                      core halted (RUN only)
//   DONE, PASS, FAIL          verdict flags, registered
//   FAIL_CODE/IDX/VALUE       failure details, zero unless FAIL
//   PASS_CNT                  entries passed so far
//   CYCLE                     RUN cycle counter, saturating
module riscv_retire_checker
  import riscv_check_pkg::*;
#(
  parameter int NUM_TEST       = NUM_TEST_DEF,
  parameter int IDX_W          = IDX_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EXP_WE,
  input  logic [IDX_W-1:0] EXP_ADDR,
  input  logic [31:0]      EXP_NUM_INST,
  input  logic [31:0]      EXP_ANS,
  input  logic [IDX_W:0]   N_ENTRIES,
  input  logic             START,
  input  logic [31:0]      NUM_INST,
  input  logic [31:0]      OUTPUT_PORT,
  input  logic             HALT,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL,
  output logic [1:0]       FAIL_CODE,
  output logic [IDX_W-1:0] FAIL_IDX,
  output logic [31:0]      FAIL_VALUE,
  output logic [IDX_W:0]   PASS_CNT,
  output logic [31:0]      CYCLE
);

  localparam logic [IDX_W:0] NT_W = (IDX_W+1)'(NUM_TEST);
`ifdef RETIRE_CHECKER_TIMEOUT_EN
  localparam logic [31:0] TO_W = 32'(TIMEOUT_CYCLES);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  state_e           state_q;
  logic [IDX_W:0]   active_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   pass_cnt_q;
  logic [31:0]      cycle_q;
  logic             pass_q, fail_q;
  logic [1:0]       fail_code_q;
  logic [IDX_W-1:0] fail_idx_q;
  logic [31:0]      fail_value_q;

  logic [63:0]      exp_entry;
  logic [31:0]      exp_num, exp_ans;

  retire_exp_table #(
    .NUM_TEST (NUM_TEST),
    .IDX_W    (IDX_W)
  ) u_table (
    .CLK     (CLK),
    .we_i    (EXP_WE && (state_q == ST_IDLE)),
    .waddr_i (EXP_ADDR),
    .wdata_i ({EXP_NUM_INST, EXP_ANS}),
    .raddr_i (ptr_q),
    .rdata_o (exp_entry)
  );

  assign exp_num = exp_entry[63:32];
  assign exp_ans = exp_entry[31:0];

  logic             hit, match, skip, last;
  logic [IDX_W-1:0] ptr_d, fail_ptr;
  logic [IDX_W:0]   pass_cnt_d, active_d;
  logic [31:0]      cycle_d;

  always_comb begin
    hit        = (NUM_INST == exp_num);
    match      = hit && (OUTPUT_PORT == exp_ans);
    skip       = (NUM_INST > exp_num);
    ptr_d      = ptr_q + IDX_W'(1);
    pass_cnt_d = pass_cnt_q + (IDX_W+1)'(1);
    last       = (pass_cnt_d == active_q);
    // A halt/timeout in the same cycle as a pass blames the next entry.
    fail_ptr   = match ? ptr_d : ptr_q;
    cycle_d    = (&cycle_q) ? cycle_q : cycle_q + 32'd1;
    active_d   = (N_ENTRIES > NT_W) ? NT_W : N_ENTRIES;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      ptr_q        <= '0;
      pass_cnt_q   <= '0;
      cycle_q      <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= '0;
      fail_idx_q   <= '0;
      fail_value_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            active_q   <= active_d;
            ptr_q      <= '0;
            pass_cnt_q <= '0;
            cycle_q    <= '0;
            if (active_d == '0) begin
              state_q <= ST_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cycle_q <= cycle_d;
          if (match) begin
            ptr_q      <= ptr_d;
            pass_cnt_q <= pass_cnt_d;
          end
          if (match && last) begin
            state_q <= ST_PASS;
            pass_q  <= 1'b1;
          end else if (hit && !match) begin
            state_q      <= ST_FAIL;
            fail_q       <= 1'b1;
            fail_code_q  <= FC_MISMATCH;
            fail_idx_q   <= ptr_q;
            fail_value_q <= OUTPUT_PORT;
          end else if (skip) begin
            state_q      <= ST_FAIL;
            fail_q       <= 1'b1;
            fail_code_q  <= FC_SKIPPED;
            fail_idx_q   <= ptr_q;
            fail_value_q <= OUTPUT_PORT;
          end else if (HALT) begin
            state_q      <= ST_FAIL;
            fail_q       <= 1'b1;
            fail_code_q  <= FC_INCOMPLETE;
            fail_idx_q   <= fail_ptr;
            fail_value_q <= OUTPUT_PORT;
          end
`ifdef RETIRE_CHECKER_TIMEOUT_EN
          else if (cycle_d == TO_W) begin
            state_q      <= ST_FAIL;
            fail_q       <= 1'b1;
            fail_code_q  <= FC_TIMEOUT;
            fail_idx_q   <= fail_ptr;
            fail_value_q <= OUTPUT_PORT;
          end
`endif
        end
        default: ; // PASS/FAIL are terminal: everything frozen until reset
      endcase
    end
  end

  assign DONE       = pass_q | fail_q;
  assign PASS       = pass_q;
  assign FAIL       = fail_q;
  assign FAIL_CODE  = fail_code_q;
  assign FAIL_IDX   = fail_idx_q;
  assign FAIL_VALUE = fail_value_q;
  assign PASS_CNT   = pass_cnt_q;
  assign CYCLE      = cycle_q;

endmodule
